vcve2_vrf_seq: RTL and testbench

VCVE2_VRF_SEQ -- requirements
Module: vcve2_vrf_seq

---
 rtl/vcve2_pkg.sv | 40 ++++
 rtl/vcve2_vrf_seq.sv | 138 +++++++++++++
 tb/tb_vcve2_vrf_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vcve2_pkg.sv
// vcve2_pkg: shared vector types, group-size constant and LMUL-to-group helper
// Types : vlmul_e (LMUL encoding), vsew_e (element width), vrf_state_t (sequencer FSM)
// Consts: MaxVGroup, the largest register group (LMUL=8)
package vcve2_pkg;

    typedef enum logic [2:0] {
        VLMUL_1    = 3'b000,
        VLMUL_2    = 3'b001,
        VLMUL_4    = 3'b010,
        VLMUL_8    = 3'b011,
        VLMUL_RSVD = 3'b100,
        VLMUL_F8   = 3'b101,
        VLMUL_F4   = 3'b110,
        VLMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [2:0] {
        VSEW_8  = 3'b000,
        VSEW_16 = 3'b001,
        VSEW_32 = 3'b010,
        VSEW_64 = 3'b011
    } vsew_e;

    typedef enum logic [2:0] {
        VRF_IDLE,
        VRF_READ1,
        VRF_READ2,
        VRF_READ3,
        V_OP,
        VRF_WRITE
    } vrf_state_t;

    localparam int unsigned MaxVGroup = 8;

    // Fractional and reserved encodings map to a single register; reserved is rejected elsewhere.
    function automatic logic [3:0] vlmul_group(vlmul_e l);
        return l == VLMUL_2 ? 4'd2 : l == VLMUL_4 ? 4'd4 : l == VLMUL_8 ? 4'd8 : 4'd1;
    endfunction

endpackage

// File: rtl/vcve2_vrf_seq.sv
// vcve2_vrf_seq: sequences VRF operand reads, ALU handshake and result write-back per register group
// In : clk_i, rst_i (async, active-high), start_i, num_src_i, vs1/vs2/vs3/vd_i, vlmul_i, wb_en_i,
//      flush_i, vrf_rdata_i, result_i, result_valid_i
// Out: ready_o, vrf_re_o, vrf_we_o, vrf_addr_o, vrf_wdata_o, op_a/b/c_o, op_valid_o, done_o, illegal_o
module vcve2_vrf_seq
    import vcve2_pkg::*;
#(
    parameter int unsigned VLEN   = 128,
    parameter int unsigned MaxSrc = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            ready_o,
    input  logic [1:0]      num_src_i,
    input  logic [4:0]      vs1_i,
    input  logic [4:0]      vs2_i,
    input  logic [4:0]      vs3_i,
    input  logic [4:0]      vd_i,
    input  logic [2:0]      vlmul_i,
    input  logic            wb_en_i,
    input  logic            flush_i,
    output logic            vrf_re_o,
    output logic            vrf_we_o,
    output logic [4:0]      vrf_addr_o,
    input  logic [VLEN-1:0] vrf_rdata_i,
    output logic [VLEN-1:0] vrf_wdata_o,
    output logic [VLEN-1:0] op_a_o,
    output logic [VLEN-1:0] op_b_o,
    output logic [VLEN-1:0] op_c_o,
    output logic            op_valid_o,
    input  logic [VLEN-1:0] result_i,
    input  logic            result_valid_i,
    output logic            done_o,
    output logic            illegal_o
);

    vrf_state_t      state_q, state_d;
    logic [3:0]      g_q, g_d, grp_q;
    logic [1:0]      nsrc_q;
    logic [4:0]      vs1_q, vs2_q, vs3_q, vd_q;
    logic            wb_q, illegal_q;
    logic [VLEN-1:0] op_a_q, op_b_q, op_c_q, res_q;

    logic            accept, bad, misalign, last, op_done, grp_end;
    logic [1:0]      nsrc_in;
    logic [3:0]      grp_in;
    logic [4:0]      msk, rd_base;
    vrf_state_t      grp_start;

    assign accept  = start_i && state_q == VRF_IDLE;
    // Counts above MaxSrc are clamped so the read chain never exceeds the configured width.
    assign nsrc_in = num_src_i > 2'(MaxSrc) ? 2'(MaxSrc) : num_src_i;
    assign grp_in  = vlmul_group(vlmul_e'(vlmul_i));
    assign msk     = 5'(grp_in) - 5'd1;
    // A used base register must be aligned to the group size.
    assign misalign = (nsrc_in >= 2'd1 && |(vs1_i & msk)) || (nsrc_in >= 2'd2 && |(vs2_i & msk)) ||
                      (nsrc_in == 2'd3 && |(vs3_i & msk)) || (wb_en_i && |(vd_i & msk));
    assign bad      = accept && (vlmul_i == VLMUL_RSVD || misalign);

    assign last      = g_q == grp_q - 4'd1;
    assign op_done   = state_q == V_OP && result_valid_i;
    assign grp_end   = (op_done && !wb_q) || state_q == VRF_WRITE;
    assign grp_start = nsrc_q != 2'd0 ? VRF_READ1 : V_OP;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            VRF_IDLE:  if (accept && !bad) begin
                state_d = nsrc_in != 2'd0 ? VRF_READ1 : V_OP;
                g_d     = 4'd0;
            end
            VRF_READ1: state_d = nsrc_q >= 2'd2 ? VRF_READ2 : V_OP;
            VRF_READ2: state_d = nsrc_q == 2'd3 ? VRF_READ3 : V_OP;
            VRF_READ3: state_d = V_OP;
            V_OP:      if (result_valid_i) state_d = wb_q ? VRF_WRITE : last ? VRF_IDLE : grp_start;
            VRF_WRITE: state_d = last ? VRF_IDLE : grp_start;
            default:   state_d = VRF_IDLE;
        endcase
        if (grp_end && !last) g_d = g_q + 4'd1;
        // Flush outranks everything else, including a same-cycle result.
        if (flush_i && state_q != VRF_IDLE) begin
            state_d = VRF_IDLE;
            g_d     = 4'd0;
        end
    end

    assign rd_base     = state_q == VRF_READ1 ? vs1_q : state_q == VRF_READ2 ? vs2_q : vs3_q;
    assign vrf_re_o    = !flush_i && (state_q == VRF_READ1 || state_q == VRF_READ2 || state_q == VRF_READ3);
    assign vrf_we_o    = !flush_i && state_q == VRF_WRITE;
    assign vrf_addr_o  = vrf_re_o ? rd_base + 5'(g_q) : vrf_we_o ? vd_q + 5'(g_q) : 5'd0;
    assign vrf_wdata_o = vrf_we_o ? res_q : '0;
    assign done_o      = grp_end && last && !flush_i;
    assign ready_o     = state_q == VRF_IDLE;
    assign op_valid_o  = state_q == V_OP;
    assign illegal_o   = illegal_q;
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign op_c_o      = op_c_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= VRF_IDLE;
            g_q       <= 4'd0;
            grp_q     <= 4'd1;
            nsrc_q    <= 2'd0;
            vs1_q     <= 5'd0;
            vs2_q     <= 5'd0;
            vs3_q     <= 5'd0;
            vd_q      <= 5'd0;
            wb_q      <= 1'b0;
            illegal_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_c_q    <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            illegal_q <= bad;
            if (accept && !bad) begin
                grp_q  <= grp_in;
                nsrc_q <= nsrc_in;
                vs1_q  <= vs1_i;
                vs2_q  <= vs2_i;
                vs3_q  <= vs3_i;
                vd_q   <= vd_i;
                wb_q   <= wb_en_i;
            end
            if (vrf_re_o && state_q == VRF_READ1) op_a_q <= vrf_rdata_i;
            if (vrf_re_o && state_q == VRF_READ2) op_b_q <= vrf_rdata_i;
            if (vrf_re_o && state_q == VRF_READ3) op_c_q <= vrf_rdata_i;
            if (op_done && !flush_i) res_q <= result_i;
        end
    end

endmodule

// File: tb/tb_vcve2_vrf_seq.sv
// tb_vcve2_vrf_seq: directed self-checking bench for the VRF sequencer
module tb_vcve2_vrf_seq;

    localparam int VLEN = 128;

    typedef struct {
        bit               w;
        int               a;
        logic [VLEN-1:0]  d;
    } ent_t;

    logic            clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, wb_en_i = 1'b0, flush_i = 1'b0;
    logic            ready_o, vrf_re_o, vrf_we_o, op_valid_o, done_o, illegal_o, result_valid_i;
    logic [1:0]      num_src_i = '0;
    logic [4:0]      vs1_i = '0, vs2_i = '0, vs3_i = '0, vd_i = '0, vrf_addr_o;
    logic [2:0]      vlmul_i = '0;
    logic [VLEN-1:0] vrf_rdata_i, vrf_wdata_o, op_a_o, op_b_o, op_c_o, result_i;

    int   errors = 0, checks = 0;
    int   cyc = 0, vop_cnt = 0, rv_delay = 0;
    int   done_n = 0, ill_n = 0, busy_n = 0, opv_n = 0, stab_n = 0, viol_n = 0;
    int   done_cyc = 0, ill_cyc = 0;
    bit   stab_en = 1'b0;
    logic [VLEN-1:0] exp_a = '0, exp_b = '0;
    ent_t log_q[$];

    vcve2_vrf_seq #(.VLEN(VLEN), .MaxSrc(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
        .num_src_i(num_src_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .vs3_i(vs3_i), .vd_i(vd_i),
        .vlmul_i(vlmul_i), .wb_en_i(wb_en_i), .flush_i(flush_i),
        .vrf_re_o(vrf_re_o), .vrf_we_o(vrf_we_o), .vrf_addr_o(vrf_addr_o),
        .vrf_rdata_i(vrf_rdata_i), .vrf_wdata_o(vrf_wdata_o),
        .op_a_o(op_a_o), .op_b_o(op_b_o), .op_c_o(op_c_o), .op_valid_o(op_valid_o),
        .result_i(result_i), .result_valid_i(result_valid_i),
        .done_o(done_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    function automatic logic [VLEN-1:0] vv(input int i);
        return VLEN'(i * 1000 + 7) | (VLEN'(i) << 100);
    endfunction

    assign vrf_rdata_i    = vv(int'(vrf_addr_o));
    assign result_i       = op_a_o + op_b_o + op_c_o;
    assign result_valid_i = op_valid_o && vop_cnt >= rv_delay;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        vop_cnt <= op_valid_o ? vop_cnt + 1 : 0;
    end

    always @(negedge clk) if (!rst_i) begin
        if (vrf_re_o) log_q.push_back('{w: 1'b0, a: int'(vrf_addr_o), d: '0});
        if (vrf_we_o) log_q.push_back('{w: 1'b1, a: int'(vrf_addr_o), d: vrf_wdata_o});
        if (vrf_re_o && vrf_we_o) viol_n++;
        if (!vrf_re_o && !vrf_we_o && vrf_addr_o != 5'd0) viol_n++;
        if (done_o) begin done_n++; done_cyc = cyc; end
        if (illegal_o) begin ill_n++; ill_cyc = cyc; end
        if (!ready_o) busy_n++;
        if (op_valid_o) begin
            opv_n++;
            if (stab_en && (op_a_o !== exp_a || op_b_o !== exp_b)) stab_n++;
        end
    end

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ent(input string tag, input int idx, input bit w, input int a, input logic [VLEN-1:0] d);
        logic [159:0] got;
        got = '1;
        if (idx < log_q.size()) got = {26'd0, log_q[idx].w, 5'(log_q[idx].a), log_q[idx].d};
        chk(tag, got, {26'd0, w, 5'(a), d});
    endtask

    task automatic reset_dut();
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
    endtask

    // Drives one request for a single cycle, then scrambles the request fields so any re-sampling shows up.
    task automatic do_op(input logic [1:0] ns, input int v1, input int v2, input int v3, input int vd,
                         input logic [2:0] lm, input logic wb, output int acc);
        @(posedge clk); #1;
        start_i = 1'b1; num_src_i = ns; vs1_i = 5'(v1); vs2_i = 5'(v2); vs3_i = 5'(v3);
        vd_i = 5'(vd); vlmul_i = lm; wb_en_i = wb; acc = cyc;
        @(posedge clk); #1;
        start_i = 1'b0; num_src_i = 2'd3; vs1_i = 5'h1f; vs2_i = 5'h1e; vs3_i = 5'h1d;
        vd_i = 5'h1c; vlmul_i = 3'b011; wb_en_i = 1'b0;
    endtask

    task automatic wait_evt(input int bd, input int bi);
        int n = 0;
        while (done_n == bd && ill_n == bi && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 200) chk("timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_basic(input string p);
        int acc, lb, bd;
        lb = log_q.size(); bd = done_n;
        do_op(2'd2, 4, 8, 0, 12, 3'b000, 1'b1, acc);
        wait_evt(bd, ill_n);
        chk({p, "_rd4"}, 0, 0);
        chk_ent({p, "_rd4"}, lb, 1'b0, 4, '0);
        chk_ent({p, "_rd8"}, lb + 1, 1'b0, 8, '0);
        chk_ent({p, "_wr12"}, lb + 2, 1'b1, 12, vv(4) + vv(8));
        chk({p, "_nlog"}, log_q.size() - lb, 3);
        chk({p, "_done_n"}, done_n - bd, 1);
        chk({p, "_done_cyc"}, done_cyc - acc, 4);
        chk({p, "_ready"}, ready_o, 1);
        chk({p, "_opc_kept"}, op_c_o, 0);
    endtask

    initial begin
        int acc, lb, bd, bi, bb, bo, bs, n;
        #3;
        chk("rst_ready", ready_o, 1);
        chk("rst_re", vrf_re_o, 0);
        chk("rst_we", vrf_we_o, 0);
        chk("rst_addr", vrf_addr_o, 0);
        chk("rst_opv", op_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ill", illegal_o, 0);
        chk("rst_opa", op_a_o, 0);
        chk("rst_wdata", vrf_wdata_o, 0);
        @(negedge clk); rst_i = 1'b0;

        run_basic("b1");

        reset_dut();
        lb = log_q.size(); bd = done_n;
        do_op(2'd1, 8, 0, 0, 16, 3'b010, 1'b1, acc);
        wait_evt(bd, ill_n);
        for (int i = 0; i < 4; i++) begin
            chk_ent($sformatf("l4_rd%0d", i), lb + 2 * i, 1'b0, 8 + i, '0);
            chk_ent($sformatf("l4_wr%0d", i), lb + 2 * i + 1, 1'b1, 16 + i, vv(8 + i));
        end
        chk("l4_nlog", log_q.size() - lb, 8);
        chk("l4_done_n", done_n - bd, 1);
        chk("l4_done_cyc", done_cyc - acc, 12);
        chk("l4_opb_kept", op_b_o, 0);

        reset_dut();
        lb = log_q.size(); bd = done_n; bi = ill_n; bb = busy_n;
        do_op(2'd1, 2, 0, 0, 3, 3'b001, 1'b1, acc);
        wait_evt(bd, bi);
        chk("ill_n", ill_n - bi, 1);
        chk("ill_cyc", ill_cyc - acc, 1);
        chk("ill_nlog", log_q.size() - lb, 0);
        chk("ill_busy", busy_n - bb, 0);
        chk("ill_done", done_n - bd, 0);
        bi = ill_n;
        do_op(2'd0, 0, 0, 0, 0, 3'b100, 1'b0, acc);
        wait_evt(bd, bi);
        chk("rsvd_ill", ill_n - bi, 1);
        chk("rsvd_nlog", log_q.size() - lb, 0);

        reset_dut();
        rv_delay = 4; exp_a = vv(4); exp_b = vv(8); stab_en = 1'b1;
        lb = log_q.size(); bd = done_n; bo = opv_n; bs = stab_n;
        do_op(2'd2, 4, 8, 0, 12, 3'b000, 1'b1, acc);
        wait_evt(bd, ill_n);
        stab_en = 1'b0; rv_delay = 0;
        chk("dly_opv", opv_n - bo, 5);
        chk("dly_stable", stab_n - bs, 0);
        chk_ent("dly_wr12", lb + 2, 1'b1, 12, vv(4) + vv(8));
        chk("dly_done_cyc", done_cyc - acc, 8);

        reset_dut();
        rv_delay = 3;
        lb = log_q.size(); bd = done_n;
        do_op(2'd1, 8, 0, 0, 16, 3'b010, 1'b1, acc);
        n = 0;
        while (!(log_q.size() - lb == 5 && op_valid_o) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("fl_reach_g2", n < 200, 1);
        chk_ent("fl_rd10", lb + 4, 1'b0, 10, '0);
        flush_i = 1'b1;
        chk("fl_we", vrf_we_o, 0);
        chk("fl_done", done_o, 0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("fl_ready", ready_o, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("fl_nlog", log_q.size() - lb, 5);
        chk("fl_done_n", done_n - bd, 0);
        rv_delay = 0;

        reset_dut();
        bd = done_n;
        do_op(2'd2, 4, 8, 0, 12, 3'b001, 1'b1, acc);
        n = 0;
        while (!vrf_we_o && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rw_reach_wr", n < 200, 1);
        rst_i = 1'b1;
        #1;
        chk("rw_we", vrf_we_o, 0);
        chk("rw_ready", ready_o, 1);
        chk("rw_opa", op_a_o, 0);
        @(negedge clk); rst_i = 1'b0;
        chk("rw_done_n", done_n - bd, 0);
        run_basic("b2");
        chk("viol", viol_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
